// File: rtl/dlx_pkg.sv
// Package: dlx_pkg
// Purpose: shared definitions for the DLX instruction-fetch slice.
//   - fetch_state_e : fetch FSM states (2-bit encoding)
//   - DLX_NOP       : instruction presented to decode when nothing is valid
//   - DLX_PROG_LEN  : default program length in words; fetching stops at this PC
package dlx_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_FULL  = 2'd1,
        S_END   = 2'd2
    } fetch_state_e;

    localparam logic [31:0] DLX_NOP      = 32'h0000_0000;
    localparam int          DLX_PROG_LEN = 32;

endpackage

// File: rtl/dlx_fetch_fifo.sv
// Module: dlx_fetch_fifo
// Purpose: small synchronous FIFO holding prefetched {pc, instruction} pairs.
// Ports:
//   clk_i    in   clock, rising edge
//   reset_i  in   asynchronous active-low reset
//   flush_i  in   empties the FIFO; wins over push and pop
//   push_i   in   write data_i (ignored when full unless popping too)
//   data_i   in   entry to write
//   pop_i    in   remove the head entry (ignored when empty)
//   head_o   out  current head entry (contents undefined-but-stable when empty)
//   count_o  out  number of valid entries
//   full_o   out  count == DEPTH
//   empty_o  out  count == 0
module dlx_fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is only allowed when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/dlx_fetch_unit.sv
// Module: dlx_fetch_unit
// Purpose: DLX instruction-fetch initiator. Owns the fetch PC, addresses the
//   combinational instruction ROM, buffers returned words in a prefetch FIFO and
//   hands {instruction, pc} to decode over a valid/ready handshake. Redirects
//   from decode flush all prefetched work and restart fetch at the target.
// Ports:
//   clk_i          in   clock, rising edge
//   reset_i        in   asynchronous active-low reset
//   rom_addr_o     out  word address to the ROM (registered fetch PC)
//   rom_data_i     in   ROM word for rom_addr_o, same cycle
//   redirect_i     in   taken branch/jump from decode
//   redirect_pc_i  in   redirect target word address
//   inst_o         out  head instruction, NOP when not valid
//   inst_pc_o      out  word address of inst_o, 0 when not valid
//   inst_valid_o   out  head entry valid
//   inst_ready_i   in   decode accepts the head this cycle
//   fetch_done_o   out  program exhausted and FIFO drained (registered)
module dlx_fetch_unit
    import dlx_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                FIFO_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter logic [ADDR_W-1:0] PROG_LEN   = ADDR_W'(DLX_PROG_LEN)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_data_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic              fetch_done_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int ENT_W = ADDR_W + DATA_W;
    localparam fetch_state_e RESET_STATE = (RESET_PC >= PROG_LEN) ? S_END : S_FETCH;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              fetch_done_q, fetch_done_d;

    logic [ADDR_W-1:0] pc_inc;
    logic              pop;
    logic              push;
    logic [ENT_W-1:0]  fifo_head;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    dlx_fetch_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .flush_i (redirect_i),
        .push_i  (push),
        .data_i  ({fetch_pc_q, rom_data_i}),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign pc_inc = fetch_pc_q + ADDR_W'(1);
    assign pop    = !fifo_empty && inst_ready_i;

    // Redirect outranks everything: the FIFO flush discards any pop, and the
    // target PC is fetched starting next cycle. S_END is exactly "PC at or past
    // PROG_LEN", which is why both entry paths compare against PROG_LEN.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        push         = 1'b0;
        fetch_done_d = (state_q == S_END) && fifo_empty;
        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i;
            state_d    = (redirect_pc_i >= PROG_LEN) ? S_END : S_FETCH;
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    if (!fifo_full || pop) begin
                        push       = 1'b1;
                        fetch_pc_d = pc_inc;
                        if (pc_inc >= PROG_LEN) begin
                            state_d = S_END;
                        end else if (fifo_count == CNT_W'(FIFO_DEPTH - 1) && !pop) begin
                            state_d = S_FULL;
                        end
                    end
                end
                S_FULL: begin
                    // Leaving S_FULL costs one fetch slot; the push resumes next cycle.
                    if (pop) begin
                        state_d = S_FETCH;
                    end
                end
                S_END: begin
                end
                default: begin
                    state_d = S_END;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q      <= RESET_STATE;
            fetch_pc_q   <= RESET_PC;
            fetch_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            fetch_done_q <= fetch_done_d;
        end
    end

    assign rom_addr_o   = fetch_pc_q;
    assign inst_valid_o = !fifo_empty;
    assign inst_o       = fifo_empty ? DATA_W'(DLX_NOP) : fifo_head[DATA_W-1:0];
    assign inst_pc_o    = fifo_empty ? '0 : fifo_head[ENT_W-1:DATA_W];
    assign fetch_done_o = fetch_done_q;

endmodule

// File: tb/tb_dlx_fetch_unit.sv
// Testbench: tb_dlx_fetch_unit
// Purpose: directed scenarios on the HELLO-SUJAY program image followed by a
//   randomized run, all checked against a queue-based reference model.
module tb_dlx_fetch_unit;

    localparam int PROG_LEN = 32;
    localparam int DEPTH    = 2;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_data_i;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;
    logic        inst_ready_i = 1'b0;
    logic        fetch_done_o;

    logic [31:0] rom [0:31];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t      mq[$];
    logic [31:0] mPc;
    logic        mDone;

    int numTests = 0;
    int numFails = 0;

    dlx_fetch_unit dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .rom_addr_o    (rom_addr_o),
        .rom_data_i    (rom_data_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .inst_o        (inst_o),
        .inst_pc_o     (inst_pc_o),
        .inst_valid_o  (inst_valid_o),
        .inst_ready_i  (inst_ready_i),
        .fetch_done_o  (fetch_done_o)
    );

    always #5 clk_i = ~clk_i;

    // Combinational ROM; addresses past the program read as zero
    assign rom_data_i = (rom_addr_o < 32) ? rom[rom_addr_o[4:0]] : 32'h0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        numTests++;
        if (got !== exp) begin
            numFails++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        mPc   = 32'd0;
        mDone = 1'b0;
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, "_valid"}, 64'(inst_valid_o), 64'(mq.size() > 0));
        checkOutput({tag, "_inst"}, 64'(inst_o), 64'(mq.size() > 0 ? mq[0].inst : 32'h0));
        checkOutput({tag, "_pc"}, 64'(inst_pc_o), 64'(mq.size() > 0 ? mq[0].pc : 32'h0));
        checkOutput({tag, "_addr"}, 64'(rom_addr_o), 64'(mPc));
        checkOutput({tag, "_done"}, 64'(fetch_done_o), 64'(mDone));
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_rst_addr"}, 64'(rom_addr_o), 64'h0);
        checkOutput({tag, "_rst_valid"}, 64'(inst_valid_o), 64'h0);
        checkOutput({tag, "_rst_inst"}, 64'(inst_o), 64'h0);
        checkOutput({tag, "_rst_pc"}, 64'(inst_pc_o), 64'h0);
        checkOutput({tag, "_rst_done"}, 64'(fetch_done_o), 64'h0);
    endtask

    // Asserts reset at a falling edge, checks reset values, releases at a later falling edge
    task automatic doReset(input string tag);
        @(negedge clk_i);
        reset_i      = 1'b0;
        inst_ready_i = 1'b0;
        redirect_i   = 1'b0;
        modelReset();
        #1;
        checkResetValues(tag);
        repeat (2) @(negedge clk_i);
        reset_i = 1'b1;
    endtask

    // One clock: drive inputs, advance the model, then compare on the falling edge.
    // Model rules: the FIFO holds at most DEPTH entries, a fetch happens whenever
    // the PC is inside the program and the FIFO was not full at the start of the
    // cycle, and "done" means the PC is past the program with nothing buffered.
    task automatic applyStimulus(input bit rdy, input bit redir, input logic [31:0] rpc,
                                 input string tag);
        int  sizeBefore;
        bit  doPop;
        bit  doPush;
        inst_ready_i  = rdy;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        sizeBefore = mq.size();
        doPop      = (sizeBefore > 0) && rdy;
        doPush     = (mPc < PROG_LEN) && (sizeBefore < DEPTH);
        mDone      = (mPc >= PROG_LEN) && (sizeBefore == 0);
        if (redir) begin
            mq.delete();
            mPc = rpc;
        end else begin
            if (doPop) void'(mq.pop_front());
            if (doPush) begin
                mq.push_back('{pc: mPc, inst: (mPc < 32) ? rom[mPc[4:0]] : 32'h0});
                mPc = mPc + 32'd1;
            end
        end
        @(posedge clk_i);
        @(negedge clk_i);
        checkModel(tag);
    endtask

    initial begin
        bit saw;

        rom[0]  = 32'hFC000048; rom[1]  = 32'hFC000006; rom[2]  = 32'hFC000045; rom[3]  = 32'hFC00004C;
        rom[4]  = 32'hFC00004C; rom[5]  = 32'hFC00004F; rom[6]  = 32'hFC00002D; rom[7]  = 32'hFC000053;
        rom[8]  = 32'hFC000055; rom[9]  = 32'hFC00004A; rom[10] = 32'hFC000041; rom[11] = 32'hFC000059;
        rom[12] = 32'h20010000; rom[13] = 32'h20020048; rom[14] = 32'hAC220000; rom[15] = 32'h20210004;
        rom[16] = 32'h1440FFF8; rom[17] = 32'h8000003F; rom[18] = 32'h00432020; rom[19] = 32'h00432822;
        rom[20] = 32'h00A43024; rom[21] = 32'h00A43825; rom[22] = 32'h8C280000; rom[23] = 32'hAC280004;
        rom[24] = 32'h10000003; rom[25] = 32'h20090001; rom[26] = 32'h200A0002; rom[27] = 32'h012A5820;
        rom[28] = 32'h3C0C1234; rom[29] = 32'h358C5678; rom[30] = 32'h0800001F; rom[31] = 32'h403C0007;

        // Streaming from reset with decode always ready
        doReset("t1");
        applyStimulus(1, 0, 0, "t1_c1");
        checkOutput("t1_pc0", 64'(inst_pc_o), 64'h0);
        checkOutput("t1_inst0", 64'(inst_o), 64'hFC000048);
        applyStimulus(1, 0, 0, "t1_c2");
        checkOutput("t1_pc1", 64'(inst_pc_o), 64'h1);
        checkOutput("t1_inst1", 64'(inst_o), 64'hFC000006);
        for (int k = 2; k < 6; k++) begin
            applyStimulus(1, 0, 0, "t1_run");
            checkOutput("t1_nobubble_valid", 64'(inst_valid_o), 64'h1);
            checkOutput("t1_nobubble_pc", 64'(inst_pc_o), 64'(k));
        end

        // Back-pressure fills the FIFO, then drains in order
        doReset("t2");
        repeat (5) applyStimulus(0, 0, 0, "t2_stall");
        checkOutput("t2_addr_hold", 64'(rom_addr_o), 64'h2);
        for (int k = 0; k < 3; k++) begin
            checkOutput("t2_order_pc", 64'(inst_pc_o), 64'(k));
            applyStimulus(1, 0, 0, "t2_drain");
        end

        // Redirect while full
        doReset("t3");
        repeat (3) applyStimulus(0, 0, 0, "t3_fill");
        checkOutput("t3_full_addr", 64'(rom_addr_o), 64'h2);
        applyStimulus(1, 1, 32'h11, "t3_redir");
        checkOutput("t3_bubble", 64'(inst_valid_o), 64'h0);
        applyStimulus(0, 0, 0, "t3_target");
        checkOutput("t3_tgt_pc", 64'(inst_pc_o), 64'h11);
        checkOutput("t3_tgt_inst", 64'(inst_o), 64'h8000003F);

        // Free run to the end of the program (bounded)
        saw = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (inst_valid_o && inst_pc_o == 32'h1F) begin
                saw = 1'b1;
                checkOutput("t4_last_inst", 64'(inst_o), 64'h403C0007);
            end
            if (fetch_done_o) break;
            applyStimulus(1, 0, 0, "t4_run");
        end
        checkOutput("t4_saw_last", 64'(saw), 64'h1);
        checkOutput("t4_done", 64'(fetch_done_o), 64'h1);
        checkOutput("t4_end_valid", 64'(inst_valid_o), 64'h0);
        checkOutput("t4_end_addr", 64'(rom_addr_o), 64'h20);
        repeat (3) applyStimulus(1, 0, 0, "t4_hold");
        checkOutput("t4_done_held", 64'(fetch_done_o), 64'h1);

        // Redirect past the program end
        doReset("t5");
        repeat (2) applyStimulus(1, 0, 0, "t5_run");
        applyStimulus(1, 1, 32'h40, "t5_redir");
        checkOutput("t5_done_early", 64'(fetch_done_o), 64'h0);
        checkOutput("t5_addr", 64'(rom_addr_o), 64'h40);
        applyStimulus(1, 0, 0, "t5_wait");
        checkOutput("t5_done", 64'(fetch_done_o), 64'h1);
        checkOutput("t5_nofetch", 64'(inst_valid_o), 64'h0);

        // Asynchronous reset between edges mid-run
        doReset("t6a");
        repeat (4) applyStimulus(1, 0, 0, "t6_run");
        #2;
        reset_i = 1'b0;
        modelReset();
        #1;
        checkResetValues("t6_async");
        @(negedge clk_i);
        reset_i = 1'b1;
        applyStimulus(1, 0, 0, "t6_restart");
        checkOutput("t6_restart_pc", 64'(inst_pc_o), 64'h0);
        checkOutput("t6_restart_inst", 64'(inst_o), 64'hFC000048);

        // Randomized traffic with occasional redirects, some past the program end
        doReset("rnd");
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                          32'($urandom_range(0, 40)), "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", numTests, numFails);
        $finish;
    end

endmodule
